// File: rtl/mips_pkg.sv
// Shared types and constants for the Execute-stage multiply/divide unit.
package mips_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdstate_t;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of shift-add multiply or restoring divide on a {hi,lo} accumulator.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opb,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opb};
        // Shifted partial remainder is WIDTH+1 bits; top bit of the difference is the borrow.
        w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opb};
        o_acc   = i_acc;
        if (i_is_div) begin
            if (w_trial[WIDTH]) begin
                o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
            end else begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end
        end else if (i_acc[0]) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else begin
            o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide with HI/LO registers; 32 RUN cycles plus one FIX cycle.
module muldiv_hilo
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       mdopE,
    input  logic             hienE,
    input  logic             loenE,
    input  logic             abortE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             busyE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdstate_t           r_state;
    logic               r_busy;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_srca;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    mdop_t              w_op;
    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    always_comb begin
        w_op        = mdop_t'(mdopE);
        w_is_signed = (w_op == MULT) || (w_op == DIV);
        w_a_neg     = w_is_signed && srcaE[WIDTH-1];
        w_b_neg     = w_is_signed && srcbE[WIDTH-1];
        w_a_mag     = w_a_neg ? (-srcaE) : srcaE;
        w_b_mag     = w_b_neg ? (-srcbE) : srcbE;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_opb    (r_opb),
        .o_acc    (w_acc_next)
    );

    // Divide-by-zero bypasses the sign fix so HI returns the untouched dividend.
    always_comb begin
        w_prod   = r_neg_q ? (-r_acc) : r_acc;
        w_quo    = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = r_div0 ? r_srca : w_rem;
            w_fix_lo = r_div0 ? '1 : w_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_srca   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (startE) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opb    <= w_b_mag;
                        r_is_div <= w_op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= (srcbE == '0);
                        r_srca   <= srcaE;
                    end else begin
                        if (hienE) r_hi <= srcaE;
                        if (loenE) r_lo <= srcaE;
                    end
                end
                RUN: begin
                    if (abortE) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST) r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!abortE) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busyE = r_busy;
    assign hiE   = r_hi;
    assign loE   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed vector table plus hand sequences for mthi/mtlo, abort and mid-op reset.
module tb_muldiv_hilo;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        startE;
    logic [1:0]  mdopE;
    logic        hienE;
    logic        loenE;
    logic        abortE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        busyE;
    logic [31:0] hiE;
    logic [31:0] loE;

    int total;
    int bad;

    typedef struct {
        mdop_t       op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .mdopE  (mdopE),
        .hienE  (hienE),
        .loenE  (loenE),
        .abortE (abortE),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .busyE  (busyE),
        .hiE    (hiE),
        .loE    (loE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the first idle negedge after completion.
    task automatic run_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic hien, input logic abrt, output int n);
        mdopE  = op;
        srcaE  = a;
        srcbE  = b;
        startE = 1'b1;
        hienE  = hien;
        abortE = abrt;
        @(negedge clk);
        startE = 1'b0;
        hienE  = 1'b0;
        abortE = 1'b0;
        n = 0;
        while (busyE === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        hienE = 1'b1;
        srcaE = h;
        @(negedge clk);
        hienE = 1'b0;
        loenE = 1'b1;
        srcaE = l;
        @(negedge clk);
        loenE = 1'b0;
    endtask

    initial begin
        int n;
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        startE = 1'b0;
        mdopE  = 2'b00;
        hienE  = 1'b0;
        loenE  = 1'b0;
        abortE = 1'b0;
        srcaE  = '0;
        srcbE  = '0;

        vecs[0]  = '{op: MULTU, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001};
        vecs[1]  = '{op: MULT,  a: 32'hFFFFFFFD, b: 32'h00000007, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB};
        vecs[2]  = '{op: DIV,   a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD};
        vecs[3]  = '{op: DIVU,  a: 32'd100,      b: 32'h00000000, hi: 32'd100,      lo: 32'hFFFFFFFF};
        vecs[4]  = '{op: DIV,   a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000};
        vecs[5]  = '{op: MULT,  a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, hi: 32'h3FFFFFFF, lo: 32'h00000001};
        vecs[6]  = '{op: DIVU,  a: 32'hFFFFFFFF, b: 32'h00000010, hi: 32'h0000000F, lo: 32'h0FFFFFFF};
        vecs[7]  = '{op: DIV,   a: 32'h00000007, b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD};
        vecs[8]  = '{op: DIV,   a: 32'hFFFFFFFB, b: 32'h00000000, hi: 32'hFFFFFFFB, lo: 32'hFFFFFFFF};
        vecs[9]  = '{op: MULT,  a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000};
        vecs[10] = '{op: MULT,  a: 32'hFFFFFFFF, b: 32'h00000001, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFF};
        vecs[11] = '{op: DIVU,  a: 32'h12345678, b: 32'h00001234, hi: 32'h00000DA8, lo: 32'h00010004};
        vecs[12] = '{op: MULTU, a: 32'h12345678, b: 32'h00000010, hi: 32'h00000001, lo: 32'h23456780};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busyE}, 32'd0);
        check("reset_hi", hiE, 32'd0);
        check("reset_lo", loE, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back: each op starts in the first idle cycle after the previous one.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, n);
            check($sformatf("v%0d_busy_cycles", i), n, 32'd33);
            check($sformatf("v%0d_hi", i), hiE, vecs[i].hi);
            check($sformatf("v%0d_lo", i), loE, vecs[i].lo);
        end

        write_hilo(32'h00001234, 32'h00005678);
        check("mthi", hiE, 32'h00001234);
        check("mtlo", loE, 32'h00005678);

        hienE = 1'b1;
        loenE = 1'b1;
        srcaE = 32'h0000AAAA;
        @(negedge clk);
        hienE = 1'b0;
        loenE = 1'b0;
        check("mthilo_both_hi", hiE, 32'h0000AAAA);
        check("mthilo_both_lo", loE, 32'h0000AAAA);

        run_op(MULTU, 32'd5, 32'd6, 1'b1, 1'b0, n);
        check("start_hien_busy_cycles", n, 32'd33);
        check("start_hien_hi", hiE, 32'd0);
        check("start_hien_lo", loE, 32'd30);

        run_op(MULTU, 32'd2, 32'd3, 1'b0, 1'b1, n);
        check("idle_abort_busy_cycles", n, 32'd33);
        check("idle_abort_lo", loE, 32'd6);

        write_hilo(32'h00001111, 32'h00002222);
        mdopE  = MULTU;
        srcaE  = 32'd3;
        srcbE  = 32'd3;
        startE = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        repeat (9) @(negedge clk);
        abortE = 1'b1;
        @(negedge clk);
        abortE = 1'b0;
        check("abort_run_busy", {31'b0, busyE}, 32'd0);
        check("abort_run_hi", hiE, 32'h00001111);
        check("abort_run_lo", loE, 32'h00002222);
        repeat (40) @(negedge clk);
        check("abort_run_late_hi", hiE, 32'h00001111);
        check("abort_run_late_lo", loE, 32'h00002222);

        write_hilo(32'h00003333, 32'h00004444);
        mdopE  = MULTU;
        srcaE  = 32'd7;
        srcbE  = 32'd7;
        startE = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        repeat (32) @(negedge clk);
        check("pre_fix_busy", {31'b0, busyE}, 32'd1);
        abortE = 1'b1;
        @(negedge clk);
        abortE = 1'b0;
        check("abort_fix_busy", {31'b0, busyE}, 32'd0);
        check("abort_fix_hi", hiE, 32'h00003333);
        check("abort_fix_lo", loE, 32'h00004444);

        write_hilo(32'h00005555, 32'h00006666);
        mdopE  = DIVU;
        srcaE  = 32'd100;
        srcbE  = 32'd7;
        startE = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midop_reset_busy", {31'b0, busyE}, 32'd0);
        check("midop_reset_hi", hiE, 32'd0);
        check("midop_reset_lo", loE, 32'd0);
        run_op(DIVU, 32'd100, 32'd7, 1'b0, 1'b0, n);
        check("post_reset_busy_cycles", n, 32'd33);
        check("post_reset_hi", hiE, 32'd2);
        check("post_reset_lo", loE, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
